// File: rtl/control_unit.sv
// rtl/control_unit.sv - hardwired fetch/decode/execute sequencer driving datapath controls
// One micro-step per clk; outputs are decoded combinationally from state and IR[31:27].
module control_unit #(
  parameter int DIV_WAIT      = 32,
  parameter int START_PC_HOLD = 1
) (
  input  logic        clk,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        stop,
  output logic        PCout,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        HIout,
  output logic        LOout,
  output logic        Inportout,
  output logic        Cout,
  output logic        BAout,
  output logic        PCin,
  output logic        IRin,
  output logic        MARin,
  output logic        Yin,
  output logic        Zin,
  output logic        MDRin,
  output logic        HIin,
  output logic        LOin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        read,
  output logic        write,
  output logic        OutPort,
  output logic        AND,
  output logic        OR,
  output logic        ADD,
  output logic        SUB,
  output logic        MUL,
  output logic        DIV,
  output logic        SHR,
  output logic        SHL,
  output logic        ROR,
  output logic        ROL,
  output logic        NEG,
  output logic        NOT,
  output logic        IncPC,
  output logic        run,
  output logic        illegal
);

  typedef enum logic [3:0] {
    S_RESET, S_PAUSE, S_HALT,
    S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7
  } state_t;

  localparam int DCW = (DIV_WAIT > 0) ? $clog2(DIV_WAIT + 1) : 1;
  localparam int HCW = (START_PC_HOLD > 1) ? $clog2(START_PC_HOLD) : 1;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_ST   = 5'b00001;
  localparam logic [4:0] OP_ADD  = 5'b00010;
  localparam logic [4:0] OP_SUB  = 5'b00011;
  localparam logic [4:0] OP_AND  = 5'b00100;
  localparam logic [4:0] OP_OR   = 5'b00101;
  localparam logic [4:0] OP_SHR  = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b01001;
  localparam logic [4:0] OP_ADDI = 5'b01010;
  localparam logic [4:0] OP_ANDI = 5'b01011;
  localparam logic [4:0] OP_ORI  = 5'b01100;
  localparam logic [4:0] OP_MUL  = 5'b01101;
  localparam logic [4:0] OP_DIV  = 5'b01110;
  localparam logic [4:0] OP_NEG  = 5'b01111;
  localparam logic [4:0] OP_NOT  = 5'b10000;
  localparam logic [4:0] OP_JR   = 5'b10001;
  localparam logic [4:0] OP_IN   = 5'b10010;
  localparam logic [4:0] OP_OUT  = 5'b10011;
  localparam logic [4:0] OP_MFHI = 5'b10100;
  localparam logic [4:0] OP_MFLO = 5'b10101;
  localparam logic [4:0] OP_NOP  = 5'b11000;
  localparam logic [4:0] OP_HALT = 5'b11001;

  state_t         state, next;
  logic [DCW-1:0] div_cnt;
  logic [HCW-1:0] hold_cnt;
  logic [4:0]     op;
  logic           is_alu3, is_imm, is_mem, is_muldiv, is_unary, op_legal;
  logic           div_done, alu_en;
  state_t         end_next;

  assign op        = IR[31:27];
  assign is_alu3   = (op >= OP_ADD) && (op <= OP_ROL);
  assign is_imm    = (op >= OP_ADDI) && (op <= OP_ORI);
  assign is_mem    = (op == OP_LD) || (op == OP_ST);
  assign is_muldiv = (op == OP_MUL) || (op == OP_DIV);
  assign is_unary  = (op == OP_NEG) || (op == OP_NOT);
  assign op_legal  = (op <= OP_MFLO) || (op == OP_NOP) || (op == OP_HALT);
  assign div_done  = (div_cnt == '0);
  assign end_next  = stop ? S_PAUSE : S_T0;

  always_ff @(posedge clk) begin
    if (clear) begin
      state    <= S_RESET;
      illegal  <= 1'b0;
      div_cnt  <= '0;
      hold_cnt <= '0;
    end else begin
      state <= next;
      if (state == S_RESET) hold_cnt <= hold_cnt + HCW'(1);
      else                  hold_cnt <= '0;
      // Counter is armed on every T4 entry; only DIV consults it.
      if (state == S_T3 && next == S_T4)       div_cnt <= DCW'(DIV_WAIT);
      else if (state == S_T4 && !div_done)     div_cnt <= div_cnt - DCW'(1);
      if (state == S_T3 && !op_legal) illegal <= 1'b1;
    end
  end

  always_comb begin
    next      = state;
    alu_en    = 1'b0;
    PCout     = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0;
    HIout     = 1'b0; LOout    = 1'b0; Inportout = 1'b0; Cout = 1'b0;
    BAout     = 1'b0; PCin     = 1'b0; IRin    = 1'b0; MARin  = 1'b0;
    Yin       = 1'b0; Zin      = 1'b0; MDRin   = 1'b0; HIin   = 1'b0;
    LOin      = 1'b0; Gra      = 1'b0; Grb     = 1'b0; Grc    = 1'b0;
    Rin       = 1'b0; Rout     = 1'b0; read    = 1'b0; write  = 1'b0;
    OutPort   = 1'b0; AND      = 1'b0; OR      = 1'b0; ADD    = 1'b0;
    SUB       = 1'b0; MUL      = 1'b0; DIV     = 1'b0; SHR    = 1'b0;
    SHL       = 1'b0; ROR      = 1'b0; ROL     = 1'b0; NEG    = 1'b0;
    NOT       = 1'b0; IncPC    = 1'b0;
    run       = !(state == S_RESET || state == S_PAUSE || state == S_HALT);

    case (state)
      S_RESET: if (hold_cnt == HCW'(START_PC_HOLD - 1)) next = S_T0;
      S_PAUSE: if (!stop) next = S_T0;
      S_HALT:  next = S_HALT;
      S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; next = S_T1; end
      S_T1: begin Zlowout = 1'b1; PCin = 1'b1; read = 1'b1; MDRin = 1'b1; next = S_T2; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; next = S_T3; end
      S_T3: begin
        next = end_next;
        if (is_mem) begin
          Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; next = S_T4;
        end else if (is_alu3 || is_imm) begin
          Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; next = S_T4;
        end else if (is_muldiv) begin
          Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; next = S_T4;
        end else if (is_unary) begin
          Grb = 1'b1; Rout = 1'b1; alu_en = 1'b1; Zin = 1'b1; next = S_T4;
        end else begin
          case (op)
            OP_JR:   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
            OP_IN:   begin Inportout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            OP_OUT:  begin Gra = 1'b1; Rout = 1'b1; OutPort = 1'b1; end
            OP_MFHI: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            OP_MFLO: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            OP_NOP:  next = end_next;
            default: next = S_HALT;
          endcase
        end
      end
      S_T4: begin
        next = end_next;
        if (is_alu3) begin
          Grc = 1'b1; Rout = 1'b1; alu_en = 1'b1; Zin = 1'b1; next = S_T5;
        end else if (is_imm || is_mem) begin
          Cout = 1'b1; alu_en = 1'b1; Zin = 1'b1; next = S_T5;
        end else if (op == OP_MUL) begin
          Grb = 1'b1; Rout = 1'b1; alu_en = 1'b1; Zin = 1'b1; next = S_T5;
        end else if (op == OP_DIV) begin
          // Operands stay on the bus for the whole divide; Z latches on the final cycle.
          Grb = 1'b1; Rout = 1'b1; alu_en = 1'b1;
          Zin  = div_done;
          next = div_done ? S_T5 : S_T4;
        end else if (is_unary) begin
          Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end
      end
      S_T5: begin
        next = end_next;
        if (is_alu3 || is_imm) begin
          Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (is_mem) begin
          Zlowout = 1'b1; MARin = 1'b1; next = S_T6;
        end else if (is_muldiv) begin
          Zlowout = 1'b1; LOin = 1'b1; next = S_T6;
        end
      end
      S_T6: begin
        next = end_next;
        if (op == OP_LD) begin
          read = 1'b1; MDRin = 1'b1; next = S_T7;
        end else if (op == OP_ST) begin
          Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; next = S_T7;
        end else if (is_muldiv) begin
          Zhighout = 1'b1; HIin = 1'b1;
        end
      end
      S_T7: begin
        next = end_next;
        if (op == OP_LD) begin
          MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (op == OP_ST) begin
          write = 1'b1;
        end
      end
      default: next = S_RESET;
    endcase

    if (alu_en) begin
      case (op)
        OP_LD, OP_ST, OP_ADD, OP_ADDI: ADD = 1'b1;
        OP_SUB:                        SUB = 1'b1;
        OP_AND, OP_ANDI:               AND = 1'b1;
        OP_OR, OP_ORI:                 OR  = 1'b1;
        OP_SHR:                        SHR = 1'b1;
        OP_SHL:                        SHL = 1'b1;
        OP_ROR:                        ROR = 1'b1;
        OP_ROL:                        ROL = 1'b1;
        OP_MUL:                        MUL = 1'b1;
        OP_DIV:                        DIV = 1'b1;
        OP_NEG:                        NEG = 1'b1;
        OP_NOT:                        NOT = 1'b1;
        default:                       ADD = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - scoreboard bench for control_unit
module tb_control_unit;
  localparam int DW = 3;

  localparam int B_PCOUT = 0,  B_ZHI = 1,   B_ZLO = 2,   B_MDROUT = 3, B_HIOUT = 4;
  localparam int B_LOOUT = 5,  B_INP = 6,   B_COUT = 7,  B_BAOUT = 8,  B_PCIN = 9;
  localparam int B_IRIN = 10,  B_MARIN = 11, B_YIN = 12, B_ZIN = 13,   B_MDRIN = 14;
  localparam int B_HIIN = 15,  B_LOIN = 16, B_GRA = 17,  B_GRB = 18,   B_GRC = 19;
  localparam int B_RIN = 20,   B_ROUT = 21, B_READ = 22, B_WRITE = 23, B_OUTP = 24;
  localparam int B_AND = 25,   B_OR = 26,   B_ADD = 27,  B_SUB = 28,   B_MUL = 29;
  localparam int B_DIV = 30,   B_SHR = 31,  B_SHL = 32,  B_ROR = 33,   B_ROL = 34;
  localparam int B_NEG = 35,   B_NOT = 36,  B_INC = 37,  B_RUN = 38,   B_ILL = 39;

  typedef struct packed {
    logic [39:0] exp;
    logic [31:0] ir;
    logic        stop;
    logic        clr;
  } ent_t;

  logic clk, clear, stop;
  logic [31:0] IR;
  logic PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Inportout, Cout, BAout;
  logic PCin, IRin, MARin, Yin, Zin, MDRin, HIin, LOin;
  logic Gra, Grb, Grc, Rin, Rout, read, write, OutPort;
  logic AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT, IncPC;
  logic run, illegal;
  logic [39:0] obs;

  ent_t sb[$];
  int   tests = 0;
  int   failed = 0;
  logic ill = 1'b0;

  control_unit #(.DIV_WAIT(DW), .START_PC_HOLD(1)) dut (
    .clk(clk), .clear(clear), .IR(IR), .stop(stop),
    .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
    .HIout(HIout), .LOout(LOout), .Inportout(Inportout), .Cout(Cout), .BAout(BAout),
    .PCin(PCin), .IRin(IRin), .MARin(MARin), .Yin(Yin), .Zin(Zin), .MDRin(MDRin),
    .HIin(HIin), .LOin(LOin), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
    .read(read), .write(write), .OutPort(OutPort), .AND(AND), .OR(OR), .ADD(ADD),
    .SUB(SUB), .MUL(MUL), .DIV(DIV), .SHR(SHR), .SHL(SHL), .ROR(ROR), .ROL(ROL),
    .NEG(NEG), .NOT(NOT), .IncPC(IncPC), .run(run), .illegal(illegal)
  );

  assign obs = {illegal, run, IncPC, NOT, NEG, ROL, ROR, SHL, SHR, DIV, MUL, SUB, ADD, OR,
                AND, OutPort, write, read, Rout, Rin, Grc, Grb, Gra, LOin, HIin, MDRin, Zin,
                Yin, MARin, IRin, PCin, BAout, Cout, Inportout, LOout, HIout, MDRout,
                Zlowout, Zhighout, PCout};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [39:0] m(input int b);
    m = 40'd1 << b;
  endfunction

  function automatic int op_bit(input logic [4:0] op);
    case (op)
      5'd3:         op_bit = B_SUB;
      5'd4, 5'd11:  op_bit = B_AND;
      5'd5, 5'd12:  op_bit = B_OR;
      5'd6:         op_bit = B_SHR;
      5'd7:         op_bit = B_SHL;
      5'd8:         op_bit = B_ROR;
      5'd9:         op_bit = B_ROL;
      5'd13:        op_bit = B_MUL;
      5'd14:        op_bit = B_DIV;
      5'd15:        op_bit = B_NEG;
      5'd16:        op_bit = B_NOT;
      default:      op_bit = B_ADD;
    endcase
  endfunction

  task automatic push(input logic [39:0] v, input logic [31:0] ir, input logic s, input logic c);
    sb.push_back({v, ir, s, c});
  endtask

  // Expected per-cycle outputs for one instruction, T0 through its last execute step.
  task automatic push_instr(input logic [4:0] op, input int stop_at);
    logic [39:0] st[$];
    logic [31:0] ir;
    logic [39:0] o;
    ir = {op, 27'h0880000};
    o  = m(op_bit(op));
    st.push_back(m(B_PCOUT) | m(B_MARIN) | m(B_INC) | m(B_ZIN));
    st.push_back(m(B_ZLO) | m(B_PCIN) | m(B_READ) | m(B_MDRIN));
    st.push_back(m(B_MDROUT) | m(B_IRIN));
    case (op)
      5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9: begin
        st.push_back(m(B_GRB) | m(B_ROUT) | m(B_YIN));
        st.push_back(m(B_GRC) | m(B_ROUT) | o | m(B_ZIN));
        st.push_back(m(B_ZLO) | m(B_GRA) | m(B_RIN));
      end
      5'd10, 5'd11, 5'd12: begin
        st.push_back(m(B_GRB) | m(B_ROUT) | m(B_YIN));
        st.push_back(m(B_COUT) | o | m(B_ZIN));
        st.push_back(m(B_ZLO) | m(B_GRA) | m(B_RIN));
      end
      5'd0, 5'd1: begin
        st.push_back(m(B_GRB) | m(B_BAOUT) | m(B_YIN));
        st.push_back(m(B_COUT) | m(B_ADD) | m(B_ZIN));
        st.push_back(m(B_ZLO) | m(B_MARIN));
        if (op == 5'd0) begin
          st.push_back(m(B_READ) | m(B_MDRIN));
          st.push_back(m(B_MDROUT) | m(B_GRA) | m(B_RIN));
        end else begin
          st.push_back(m(B_GRA) | m(B_ROUT) | m(B_MDRIN));
          st.push_back(m(B_WRITE));
        end
      end
      5'd13, 5'd14: begin
        st.push_back(m(B_GRA) | m(B_ROUT) | m(B_YIN));
        if (op == 5'd14)
          for (int i = 0; i < DW; i++) st.push_back(m(B_GRB) | m(B_ROUT) | o);
        st.push_back(m(B_GRB) | m(B_ROUT) | o | m(B_ZIN));
        st.push_back(m(B_ZLO) | m(B_LOIN));
        st.push_back(m(B_ZHI) | m(B_HIIN));
      end
      5'd15, 5'd16: begin
        st.push_back(m(B_GRB) | m(B_ROUT) | o | m(B_ZIN));
        st.push_back(m(B_ZLO) | m(B_GRA) | m(B_RIN));
      end
      5'd17: st.push_back(m(B_GRA) | m(B_ROUT) | m(B_PCIN));
      5'd18: st.push_back(m(B_INP) | m(B_GRA) | m(B_RIN));
      5'd19: st.push_back(m(B_GRA) | m(B_ROUT) | m(B_OUTP));
      5'd20: st.push_back(m(B_HIOUT) | m(B_GRA) | m(B_RIN));
      5'd21: st.push_back(m(B_LOOUT) | m(B_GRA) | m(B_RIN));
      default: st.push_back(40'd0);
    endcase
    foreach (st[i])
      push(st[i] | m(B_RUN) | (ill ? m(B_ILL) : 40'd0), ir, (i >= stop_at), 1'b0);
  endtask

  task automatic test_reset();
    ent_t e;
    int k = 0;
    push(40'd0, 32'd0, 1'b0, 1'b1);
    push(40'd0, 32'd0, 1'b0, 1'b0);
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      tests++;
      if (obs !== e.exp) begin
        failed++;
        $display("FAIL reset step %0d: outputs %h, required %h", k, obs, e.exp);
      end
      IR = e.ir; stop = e.stop; clear = e.clr; k++;
    end
  endtask

  task automatic test_add();
    ent_t e;
    int k = 0;
    push_instr(5'b00010, 99);
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      tests++;
      if (obs !== e.exp) begin
        failed++;
        $display("FAIL add step %0d: outputs %h, required %h", k, obs, e.exp);
      end
      IR = e.ir; stop = e.stop; clear = e.clr; k++;
    end
  endtask

  task automatic test_back_to_back();
    ent_t e;
    int k = 0;
    push_instr(5'b00000, 99);
    push_instr(5'b00001, 99);
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      tests++;
      if (obs !== e.exp) begin
        failed++;
        $display("FAIL ld_st step %0d: outputs %h, required %h", k, obs, e.exp);
      end
      IR = e.ir; stop = e.stop; clear = e.clr; k++;
    end
  endtask

  task automatic test_div();
    ent_t e;
    int k = 0;
    push_instr(5'b01110, 99);
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      tests++;
      if (obs !== e.exp) begin
        failed++;
        $display("FAIL div step %0d: outputs %h, required %h", k, obs, e.exp);
      end
      IR = e.ir; stop = e.stop; clear = e.clr; k++;
    end
  endtask

  task automatic test_alu_mix();
    ent_t e;
    int k = 0;
    logic [4:0] ops[$] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12,
                           5'd13, 5'd15, 5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd24};
    foreach (ops[i]) push_instr(ops[i], 99);
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      tests++;
      if (obs !== e.exp) begin
        failed++;
        $display("FAIL mix op %0d step %0d: outputs %h, required %h", e.ir[31:27], k, obs, e.exp);
      end
      IR = e.ir; stop = e.stop; clear = e.clr; k++;
    end
  endtask

  task automatic test_stop();
    ent_t e;
    int k = 0;
    push_instr(5'b00010, 4);
    push(40'd0, {5'b00010, 27'h0880000}, 1'b1, 1'b0);
    push(40'd0, {5'b00010, 27'h0880000}, 1'b0, 1'b0);
    push_instr(5'b11000, 99);
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      tests++;
      if (obs !== e.exp) begin
        failed++;
        $display("FAIL stop step %0d: outputs %h, required %h", k, obs, e.exp);
      end
      IR = e.ir; stop = e.stop; clear = e.clr; k++;
    end
  endtask

  task automatic test_halt();
    ent_t e;
    int k = 0;
    push_instr(5'b11001, 99);
    for (int i = 0; i < 5; i++) push(40'd0, {5'b11001, 27'd0}, 1'b0, (i == 4));
    push(40'd0, 32'd0, 1'b0, 1'b0);
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      tests++;
      if (obs !== e.exp) begin
        failed++;
        $display("FAIL halt step %0d: outputs %h, required %h", k, obs, e.exp);
      end
      IR = e.ir; stop = e.stop; clear = e.clr; k++;
    end
  endtask

  task automatic test_illegal();
    ent_t e;
    int k = 0;
    push_instr(5'b11111, 99);
    ill = 1'b1;
    for (int i = 0; i < 20; i++) push(m(B_ILL), {5'b11111, 27'd0}, 1'b0, (i == 19));
    ill = 1'b0;
    push(40'd0, 32'd0, 1'b0, 1'b0);
    push_instr(5'b10010, 99);
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      tests++;
      if (obs !== e.exp) begin
        failed++;
        $display("FAIL illegal step %0d: outputs %h, required %h", k, obs, e.exp);
      end
      IR = e.ir; stop = e.stop; clear = e.clr; k++;
    end
  endtask

  initial begin
    clear = 1'b1;
    stop  = 1'b0;
    IR    = 32'd0;
    test_reset();
    test_add();
    test_back_to_back();
    test_div();
    test_alu_mix();
    test_stop();
    test_halt();
    test_illegal();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Hardwired control sequencer; the producer end of the Datapath control interface.
- Receives IR from the datapath and drives every Datapath control input: bus-source selects, register enables, ALU op selects, memory read/write and port strobes.
- Runs a fetch/decode/execute state machine, one micro-step per clk, including a multi-cycle wait for DIV.

Parameters:
- DIV_WAIT, 32, extra cycles held in the DIV execute step before Z is captured (0 means no extra cycles).
- START_PC_HOLD, 1, cycles spent in RESET after clear deasserts before the first fetch (at least 1).

Ports:
- clk  input  1  system clock, rising-edge.
- clear  input  1  synchronous active-high reset.
- IR  input  32  instruction register; opcode is IR[31:27].
- stop  input  1  pause request, sampled only at the fetch boundary.
- PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Inportout, Cout, BAout  output  1 each  bus source selects.
- PCin, IRin, MARin, Yin, Zin, MDRin, HIin, LOin  output  1 each  register load enables.
- Gra, Grb, Grc, Rin, Rout  output  1 each  register-field select and general-register in/out.
- read, write, OutPort  output  1 each  memory read/write and out-port load.
- AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT, IncPC  output  1 each  ALU op selects.
- run  output  1  high while sequencing; low in RESET, PAUSE and HALT.
- illegal  output  1  sticky flag, set when an undefined opcode is decoded.

Behaviour:
- State register encodes RESET, PAUSE, HALT and steps T0..T7. Outputs are combinational from state and IR[31:27].
- Clear and reset:
  - clear high at an edge forces RESET, clears illegal and clears the DIV counter.
  - In RESET every output is 0, including run.
  - Clear takes effect at the next edge even mid-instruction; no partial completion is required.
- Leaving RESET: after START_PC_HOLD cycles in RESET with clear low, go to T0.
- At most one bus source, and at most one ALU op, is high in any state.
- Fetch, common to all instructions:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, read, MDRin.
  - T2: MDRout, IRin.
- Decode happens in T3 from the IR value loaded at T2.
- Opcodes, with execute steps:
  - add=00010, sub=00011, and=00100, or=00101, shr=00110, shl=00111, ror=01000, rol=01001:
    - T3: Grb, Rout, Yin. T4: Grc, Rout, op, Zin. T5: Zlowout, Gra, Rin.
  - addi=01010, andi=01011, ori=01100:
    - T3: Grb, Rout, Yin. T4: Cout, op (ADD/AND/OR), Zin. T5: Zlowout, Gra, Rin.
  - ld=00000:
    - T3: Grb, BAout, Yin. T4: Cout, ADD, Zin. T5: Zlowout, MARin.
    - T6: read, MDRin. T7: MDRout, Gra, Rin.
  - st=00001:
    - T3–T5 as ld. T6: Gra, Rout, MDRin, read=0. T7: write.
  - mul=01101, div=01110:
    - T3: Gra, Rout, Yin. T4: Grb, Rout, op, Zin. T5: Zlowout, LOin. T6: Zhighout, HIin.
    - For div, T4 is held DIV_WAIT+1 cycles. The counter loads on T4 entry and decrements each cycle.
    - DIV and Grb/Rout stay asserted throughout T4; Zin is asserted only on the final T4 cycle.
  - neg=01111, not=10000:
    - T3: Grb, Rout, op, Zin. T4: Zlowout, Gra, Rin.
  - jr=10001: T3: Gra, Rout, PCin.
  - in=10010: T3: Inportout, Gra, Rin.
  - out=10011: T3: Gra, Rout, OutPort.
  - mfhi=10100: T3: HIout, Gra, Rin.
  - mflo=10101: T3: LOout, Gra, Rin.
  - nop=11000: no T3 outputs.
  - halt=11001: go to HALT; stays there until clear.
  - Any other opcode: set illegal, go to HALT.
- Leaving the last execute step: go to T0, or to PAUSE if stop=1.
  - In PAUSE all outputs are 0; return to T0 when stop=0.
  - stop raised mid-instruction has no effect until the instruction completes.
- Total cycles per instruction, fetch included:
  - ALU and immediate ops: 6. ld/st: 8. mul: 7. div: 7+DIV_WAIT.
  - neg/not: 5. jr/in/out/mfhi/mflo/nop: 4.

Test Plan:
- clear for 2 cycles then release (START_PC_HOLD=1) -> all outputs 0 during clear and for 1 cycle after; run=1 and T0 signals PCout, MARin, IncPC, Zin asserted on the next cycle.
- IR=0x1_0880000 (add) presented at T2 -> T3 Grb/Rout/Yin, T4 Grc/Rout/ADD/Zin, T5 Zlowout/Gra/Rin; T0 again on cycle 6.
- ld followed by st -> read+MDRin at T6 for ld; Gra/Rout/MDRin at T6 then write at T7 for st; 8 cycles each.
- div with DIV_WAIT=3 -> DIV high for 4 consecutive cycles, Zin high only on the 4th; LOin then HIin follow; total 10 cycles.
- opcode 11111 -> illegal=1, run=0, HALT held for 20 cycles; clear -> illegal=0, fetch restarts.
- stop=1 asserted during T4 of add -> T5 completes, then PAUSE with all outputs 0; stop=0 -> T0 next cycle.
